flush_sequencer: RTL
====================

# flush_sequencer

Sequences misprediction recovery and committed-store delivery between the reorder buffer and the rest of the core. It queues committed store IDs toward the load/store buffer, and on a flush request it performs four steps in order: drain committed stores, hold a multi-cycle reset on all speculative units, redirect the instruction fetcher, then return to idle. It replaces direct fan-out of the reorder buffer's reset/pc/store signals with an ordered, handshaked sequence.

## Interface
- `LSB_ID_W`, 4: width of a load/store buffer entry ID.
- `STORE_Q_DEPTH`, 4: committed-store queue depth; power of two, ≥2.
- `FLUSH_CYCLES`, 2: cycles `reset_out` is held high; ≥1.
- `clk_in` input 1: clock; all state updates on the rising edge.
- `rst_n_in` input 1: asynchronous active-low reset.
- `rdy_in` input 1: global ready; when low, all state and outputs freeze.
- `flush_req_in` input 1: one-cycle flush request from the ROB.
- `flush_pc_in` input 32: redirect target, sampled with `flush_req_in`.
- `store_commit_valid_in` input 1: ROB commits a store this cycle.
- `store_commit_id_in` input LSB_ID_W: load/store buffer ID of the committed store.
- `store_ack_in` input 1: load/store buffer accepts `store_id_out`.
- `lsb_store_pending_in` input 1: load/store buffer still holds committed, unwritten stores.
- `fetch_ack_in` input 1: fetcher accepts the redirect.
- `store_full_out` output 1: queue full; ROB must not commit stores.
- `store_valid_out` output 1: head of queue valid.
- `store_id_out` output LSB_ID_W: head-of-queue ID.
- `reset_out` output 1: flush to issuer, RS station, ROB, reg file and load/store buffer.
- `pc_valid_out` output 1: redirect valid.
- `pc_out` output 32: redirect target.
- `busy_out` output 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, DRAIN, FLUSH, REDIRECT.
- IDLE: on `flush_req_in`, latch `flush_pc_in` and go to DRAIN.
- DRAIN: wait until the queue is empty and `lsb_store_pending_in`=0 (sampled in the same cycle), then go to FLUSH and load the flush counter with FLUSH_CYCLES-1.
- FLUSH: `reset_out`=1. Decrement the counter each cycle; at 0, go to REDIRECT.
- REDIRECT: `pc_valid_out`=1 and `pc_out`=latched PC. On `fetch_ack_in`, go to IDLE.
- Store queue:
  - Circular FIFO with head and tail pointers of log2(STORE_Q_DEPTH) bits and a count of log2(STORE_Q_DEPTH)+1 bits; pointers wrap modulo depth.
  - Enqueue when `store_commit_valid_in` && !full, accepted in IDLE or DRAIN.
  - Dequeue on `store_valid_out` && `store_ack_in`.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - A commit while full is dropped; this is a protocol violation.
- A store commit in the same cycle as `flush_req_in` is enqueued, because it is older than the flush.
- Store commits in FLUSH or REDIRECT are ignored.
- `flush_req_in` while `busy_out`=1 is ignored; the first flush wins.
- Reset asynchronously clears the FIFO, counters and latched PC, and returns the FSM to IDLE. This also aborts any in-progress sequence.

## Timing
- Reset values:
  - `store_full_out`=0, `store_valid_out`=0, `store_id_out`=0.
  - `reset_out`=0, `pc_valid_out`=0, `pc_out`=0, `busy_out`=0.
- All outputs are registered or derived from registered state only; no input-to-output combinational paths.
- Store latency: commit in cycle N → `store_valid_out` in N+1 if the queue was empty.
- `store_full_out` reflects the count after the edge, so the ROB sees full the cycle after the filling enqueue.
- Flush with empty queue and no pending stores:
  - `flush_req_in` in cycle N.
  - DRAIN in N+1; `reset_out` high in N+2 .. N+1+FLUSH_CYCLES.
  - `pc_valid_out` high from N+2+FLUSH_CYCLES until the cycle `fetch_ack_in` is seen, inclusive.
- `rdy_in`=0 stalls every transition, counter, enqueue and dequeue. Inputs are ignored that cycle.

## Configuration
- `FLUSH_SEQ_STATS_EN` defined:
  - adds output `flush_count_out` [31:0], incremented on each IDLE→DRAIN transition; wraps at 2^32; reset 0.
  - adds output `store_drop_out` [0:0], a sticky bit set on a dropped commit while full.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

## Test plan
- Reset mid-REDIRECT: drive `rst_n_in` low → all outputs 0 asynchronously, FSM IDLE, `pc_valid_out`=0 before the next edge.
- Commit IDs 3, 5, 7 on consecutive cycles, `store_ack_in`=1 always → `store_id_out` = 3, 5, 7 in cycles 1-3 after first commit; queue empty afterwards.
- Fill queue with 4 IDs while `store_ack_in`=0:
  - `store_full_out`=1.
  - A 5th commit (ID 9) is dropped.
  - After 4 acks the IDs drain in order and 9 never appears.
- Flush with PC 0x0000_1000, FLUSH_CYCLES=2, 2 stores queued:
  - `reset_out` stays 0 until both are acked and `lsb_store_pending_in`=0.
  - Then `reset_out` is high for exactly 2 cycles.
  - Then `pc_out`=0x1000 is held until `fetch_ack_in`.
- Store commit ID 6 in the same cycle as `flush_req_in` → ID 6 is delivered before `reset_out` rises. A second `flush_req_in` during FLUSH is ignored; `pc_out` keeps the first PC.
- `rdy_in`=0 for 3 cycles during FLUSH → `reset_out` high for FLUSH_CYCLES+3 cycles total. With `FLUSH_SEQ_STATS_EN`, `flush_count_out`=1 afterwards.

Source files
------------

// File: rtl/flush_sequencer.sv
// Orders misprediction recovery (drain stores, hold reset, redirect fetch) and queues committed store IDs.
// Optional statistics ports are enabled by defining FLUSH_SEQ_STATS_EN.
module flush_sequencer #(
    parameter int unsigned LSB_ID_W      = 4,
    parameter int unsigned STORE_Q_DEPTH = 4,
    parameter int unsigned FLUSH_CYCLES  = 2
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_req_in,
    input  logic [31:0]         flush_pc_in,
    input  logic                store_commit_valid_in,
    input  logic [LSB_ID_W-1:0] store_commit_id_in,
    input  logic                store_ack_in,
    input  logic                lsb_store_pending_in,
    input  logic                fetch_ack_in,
    output logic                store_full_out,
    output logic                store_valid_out,
    output logic [LSB_ID_W-1:0] store_id_out,
    output logic                reset_out,
    output logic                pc_valid_out,
    output logic [31:0]         pc_out,
    output logic                busy_out
`ifdef FLUSH_SEQ_STATS_EN
    ,
    output logic [31:0]         flush_count_out,
    output logic [0:0]          store_drop_out
`endif
);

    localparam int unsigned PTR_W = $clog2(STORE_Q_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_REDIRECT
    } state_t;

    state_t              state_q, state_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic [31:0]         pc_q;
    logic                latch_pc;
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [CNT_W-1:0]    count_q;
    logic [LSB_ID_W-1:0] mem_q [STORE_Q_DEPTH];
    logic                full, accept_st, enq, deq;

    assign full      = (count_q == CNT_W'(STORE_Q_DEPTH));
    assign accept_st = (state_q == S_IDLE) || (state_q == S_DRAIN);
    assign enq       = store_commit_valid_in && !full && accept_st;
    assign deq       = (count_q != '0) && store_ack_in;

    // Next-state and flush counter
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        latch_pc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_req_in) begin
                    state_d  = S_DRAIN;
                    latch_pc = 1'b1;
                end
            end
            S_DRAIN: begin
                if ((count_q == '0) && !lsb_store_pending_in) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            S_FLUSH: begin
                if (fcnt_q == '0) state_d = S_REDIRECT;
                else              fcnt_d  = FC_W'(fcnt_q - 1'b1);
            end
            S_REDIRECT: begin
                if (fetch_ack_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All state freezes while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            pc_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(STORE_Q_DEPTH); i++) mem_q[i] <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (latch_pc) pc_q <= flush_pc_in;
            if (enq) begin
                mem_q[tail_q] <= store_commit_id_in;
                tail_q        <= PTR_W'(tail_q + 1'b1);
            end
            if (deq) head_q <= PTR_W'(head_q + 1'b1);
            if (enq && !deq)      count_q <= CNT_W'(count_q + 1'b1);
            else if (!enq && deq) count_q <= CNT_W'(count_q - 1'b1);
        end
    end

    assign store_full_out  = full;
    assign store_valid_out = (count_q != '0);
    assign store_id_out    = mem_q[head_q];
    assign reset_out       = (state_q == S_FLUSH);
    assign pc_valid_out    = (state_q == S_REDIRECT);
    assign pc_out          = pc_q;
    assign busy_out        = (state_q != S_IDLE);

`ifdef FLUSH_SEQ_STATS_EN
    logic [31:0] flush_cnt_q;
    logic        drop_q;

    // Flush counter and sticky dropped-commit flag
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            flush_cnt_q <= '0;
            drop_q      <= 1'b0;
        end else if (rdy_in) begin
            if (latch_pc) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (store_commit_valid_in && full && accept_st) drop_q <= 1'b1;
        end
    end

    assign flush_count_out = flush_cnt_q;
    assign store_drop_out  = drop_q;
`endif

endmodule
